// File: rtl/student_iis_pkg.sv
// Shared definitions for the student I2S transmit path: slot size, the
// stereo pair type and the bit-counter width helper.
package student_iis_pkg;

  // Every I2S slot is 32 BCLKs long; a sample must fit with room for the
  // one-bit delay after the LRCLK edge.
  localparam int IIS_SLOT_BITS = 32;

  // Default sample width used by the pair type.
  localparam int IIS_DEFAULT_DATA_SIZE = 16;

  typedef struct packed {
    logic [IIS_DEFAULT_DATA_SIZE-1:0] l;
    logic [IIS_DEFAULT_DATA_SIZE-1:0] r;
  } iis_pair_t;

  // Bits needed to count 0..data_size inclusive (counter saturates at data_size).
  function automatic int iis_cnt_width(input int data_size);
    return $clog2(data_size + 1);
  endfunction

endpackage

// File: rtl/student_iis_tx_shifter.sv
// Serialiser for one I2S slot: loads a word on an LRCLK strobe, then shifts
// it out MSB first on BCLK falling-edge strobes and pads the rest with 0.
module student_iis_tx_shifter
  import student_iis_pkg::*;
#(
  parameter int DATA_SIZE = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 i_load,
  input  logic [DATA_SIZE-1:0] i_load_data,
  input  logic                 i_bclk_fall,
  output logic                 o_sdata
);

  localparam int CNT_W = iis_cnt_width(DATA_SIZE);

  logic [DATA_SIZE-1:0] r_shift;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_sdata;

  assign o_sdata = r_sdata;

  // Load has priority over a coincident BCLK fall: that fall drives the
  // pad bit and is not counted, so the MSB lands one BCLK after the edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_shift <= '0;
      r_cnt   <= '0;
      r_sdata <= 1'b0;
    end else if (i_load) begin
      r_shift <= i_load_data;
      r_cnt   <= '0;
      r_sdata <= 1'b0;
    end else if (i_bclk_fall) begin
      if (r_cnt < CNT_W'(DATA_SIZE)) begin
        r_sdata <= r_shift[DATA_SIZE-1];
        r_shift <= {r_shift[DATA_SIZE-2:0], 1'b0};
        r_cnt   <= r_cnt + CNT_W'(1);
      end else begin
        r_sdata <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/student_iis_transmitter.sv
// I2S (Philips) transmitter for the codec DAC. Buffers one stereo pair
// behind a valid/ready handshake and hands it to the slot serialiser at
// each frame start (LRCLK fall = left slot, LRCLK rise = right slot).
// Optional build macro STUDENT_IIS_TX_MUTE_ON_UNDERRUN_EN: when defined, a
// frame that starts without a fresh pair transmits silence instead of
// repeating the previous pair.
module student_iis_transmitter
  import student_iis_pkg::*;
#(
  parameter int DATA_SIZE = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [DATA_SIZE-1:0] Data_I_L,
  input  logic [DATA_SIZE-1:0] Data_I_R,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic                 AC_LRCLK,
  input  logic                 LRCLK_Rise,
  input  logic                 LRCLK_Fall,
  input  logic                 BCLK_Fall,
  output logic                 AC_DAC_SDATA,
  output logic                 underrun_o
);

  if (DATA_SIZE < 8 || DATA_SIZE > IIS_SLOT_BITS - 1) begin : g_bad_size
    $error("DATA_SIZE must be in 8..31");
  end

  logic                 r_hold_full;
  logic [DATA_SIZE-1:0] r_hold_l;
  logic [DATA_SIZE-1:0] r_hold_r;
  logic [DATA_SIZE-1:0] r_act_l;
  logic [DATA_SIZE-1:0] r_act_r;
  logic                 r_underrun;

  logic                 w_accept;
  logic                 w_underrun;
  logic                 w_load;
  logic [DATA_SIZE-1:0] w_next_l;
  logic [DATA_SIZE-1:0] w_next_r;
  logic [DATA_SIZE-1:0] w_load_data;

  // Ready while the holding register is empty; during a frame-start cycle
  // an incoming pair bypasses the holding register.
  assign ready_o    = !r_hold_full;
  assign w_accept   = valid_i && !r_hold_full;
  assign w_underrun = LRCLK_Fall && !r_hold_full && !valid_i;
  assign underrun_o = r_underrun;

  // Pair that becomes active at the next frame start.
  always_comb begin
    w_next_l = r_act_l;
    w_next_r = r_act_r;
    if (r_hold_full) begin
      w_next_l = r_hold_l;
      w_next_r = r_hold_r;
    end else if (valid_i) begin
      w_next_l = Data_I_L;
      w_next_r = Data_I_R;
    end else begin
`ifdef STUDENT_IIS_TX_MUTE_ON_UNDERRUN_EN
      w_next_l = '0;
      w_next_r = '0;
`endif
    end
  end

  // LRCLK fall wins over a simultaneous rise; rise reloads the right word.
  assign w_load      = LRCLK_Fall || LRCLK_Rise;
  assign w_load_data = LRCLK_Fall ? w_next_l : r_act_r;

  // Holding register: emptied at frame start, filled by the handshake otherwise.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_hold_full <= 1'b0;
      r_hold_l    <= '0;
      r_hold_r    <= '0;
    end else if (LRCLK_Fall) begin
      r_hold_full <= 1'b0;
    end else if (w_accept) begin
      r_hold_full <= 1'b1;
      r_hold_l    <= Data_I_L;
      r_hold_r    <= Data_I_R;
    end
  end

  // Active pair and underrun pulse, both updated at frame start.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_act_l    <= '0;
      r_act_r    <= '0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= w_underrun;
      if (LRCLK_Fall) begin
        r_act_l <= w_next_l;
        r_act_r <= w_next_r;
      end
    end
  end

  student_iis_tx_shifter #(
    .DATA_SIZE(DATA_SIZE)
  ) u_shifter (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .i_load     (w_load),
    .i_load_data(w_load_data),
    .i_bclk_fall(BCLK_Fall),
    .o_sdata    (AC_DAC_SDATA)
  );

`ifndef SYNTHESIS
  // Strobes must agree with the word-clock level they announce.
  a_fall_level : assert property (@(posedge clk_i) disable iff (!rst_ni)
    LRCLK_Fall |-> !AC_LRCLK);
  a_rise_level : assert property (@(posedge clk_i) disable iff (!rst_ni)
    LRCLK_Rise |-> AC_LRCLK);
`else
  logic w_unused_lrclk;
  assign w_unused_lrclk = AC_LRCLK;
`endif

endmodule

// File: tb/tb_student_iis_transmitter.sv
// Bench for student_iis_transmitter: strobe generator (4 clk per BCLK,
// 64 BCLK per frame, LRCLK edges aligned with BCLK falls), a pair-queue
// model of the transmitter compared every cycle, and directed frames
// captured from the pin and checked against hand-derived bit patterns.
module tb_student_iis_transmitter;
  import student_iis_pkg::*;

  localparam int DS = 16;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic [DS-1:0] data_l, data_r;
  logic          valid_i, ready_o;
  logic          ac_lrclk, lr_rise, lr_fall, bclk_fall;
  logic          sdata, underrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  student_iis_transmitter #(.DATA_SIZE(DS)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .Data_I_L    (data_l),
    .Data_I_R    (data_r),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .AC_LRCLK    (ac_lrclk),
    .LRCLK_Rise  (lr_rise),
    .LRCLK_Fall  (lr_fall),
    .BCLK_Fall   (bclk_fall),
    .AC_DAC_SDATA(sdata),
    .underrun_o  (underrun)
  );

  // strobe generator state
  int unsigned gcnt;
  logic        gen_en;

  // model state
  iis_pair_t     m_q[$];
  iis_pair_t     m_act;
  logic [DS-1:0] m_word;
  int            m_k;
  logic          m_sdata, m_under, m_prev_bclk;

  // capture of the pin, one bit per BCLK fall
  logic [63:0] cap;
  int          cap_n;
  int          under_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Expected 64 BCLK frame: pad at each LRCLK edge, word MSB first, zero padding.
  function automatic logic [63:0] exp_frame(input logic [15:0] l, input logic [15:0] r);
    return ({48'd0, l} << 47) | ({48'd0, r} << 15);
  endfunction

  task automatic set_strobes();
    if (gen_en) begin
      bclk_fall = (gcnt % 4) == 0;
      lr_fall   = (gcnt % 256) == 0;
      lr_rise   = (gcnt % 256) == 128;
      ac_lrclk  = (gcnt % 256) >= 128;
    end else begin
      bclk_fall = 1'b0;
      lr_fall   = 1'b0;
      lr_rise   = 1'b0;
      ac_lrclk  = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_act       = '0;
    m_word      = '0;
    m_k         = 0;
    m_sdata     = 1'b0;
    m_under     = 1'b0;
    m_prev_bclk = 1'b0;
  endtask

  task automatic model_step();
    iis_pair_t p;
    m_under     = 1'b0;
    m_prev_bclk = bclk_fall;
    if (lr_fall) begin
      if (m_q.size() > 0) p = m_q.pop_front();
      else if (valid_i)   p = '{l: data_l, r: data_r};
      else begin
        m_under = 1'b1;
        p = m_act;
`ifdef STUDENT_IIS_TX_MUTE_ON_UNDERRUN_EN
        p = '0;
`endif
      end
      m_act   = p;
      m_word  = p.l;
      m_k     = 0;
      m_sdata = 1'b0;
    end else begin
      if (valid_i && m_q.size() == 0) m_q.push_back('{l: data_l, r: data_r});
      if (lr_rise) begin
        m_word  = m_act.r;
        m_k     = 0;
        m_sdata = 1'b0;
      end else if (bclk_fall) begin
        if (m_k < DS) begin
          m_sdata = m_word[DS-1-m_k];
          m_k++;
        end else begin
          m_sdata = 1'b0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("sdata", 64'(sdata), 64'(m_sdata));
    chk("ready", 64'(ready_o), 64'(m_q.size() == 0));
    chk("underrun", 64'(underrun), 64'(m_under));
    if (underrun === 1'b1) under_cnt++;
    if (m_prev_bclk && rst_ni) begin
      cap = {cap[62:0], sdata};
      cap_n++;
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge,
  // then the next cycle's strobes are applied. A completed handshake drops valid.
  task automatic tick();
    logic hs;
    hs = valid_i && ready_o;
    @(posedge clk);
    if (rst_ni) model_step();
    else        model_reset();
    @(negedge clk);
    check_outputs();
    if (hs) valid_i = 1'b0;
    gcnt++;
    set_strobes();
  endtask

  task automatic send_pair(input logic [15:0] l, input logic [15:0] r);
    int g;
    data_l  = l;
    data_r  = r;
    valid_i = 1'b1;
    g = 0;
    while (valid_i && g < 600) begin
      tick();
      g++;
    end
    if (valid_i) begin
      checks++;
      errors++;
      $display("FAIL handshake_timeout actual=%0d expected<600 cycles", g);
      valid_i = 1'b0;
    end
  endtask

  task automatic run_frame(output logic [63:0] bits, output int n);
    while ((gcnt % 256) != 0) tick();
    cap   = '0;
    cap_n = 0;
    repeat (256) tick();
    bits = cap;
    n    = cap_n;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] bits;
    int          n;

    rst_ni  = 1'b0;
    valid_i = 1'b0;
    data_l  = '0;
    data_r  = '0;
    gen_en  = 1'b0;
    gcnt    = 1;
    cap     = '0;
    cap_n   = 0;
    under_cnt = 0;
    set_strobes();
    model_reset();

    repeat (3) tick();
    chk("reset_sdata", 64'(sdata), 64'd0);
    chk("reset_ready", 64'(ready_o), 64'd1);
    chk("reset_underrun", 64'(underrun), 64'd0);

    rst_ni = 1'b1;
    gen_en = 1'b1;
    gcnt   = 1;
    set_strobes();

    // handshake and latency
    send_pair(16'hA5F0, 16'h0F3C);
    chk("ready_after_accept", 64'(ready_o), 64'd0);
    run_frame(bits, n);
    chk("frame_a5f0_0f3c", bits, 64'h52F80000_079E0000);
    chk("frame_bit_count", 64'(n), 64'd64);

    // bypass in the frame-start cycle
    data_l  = 16'h8001;
    data_r  = 16'h7FFE;
    valid_i = 1'b1;
    run_frame(bits, n);
    chk("bypass_taken", 64'(valid_i), 64'd0);
    chk("bypass_left_word", 64'(bits[62:47]), 64'h8001);
    chk("bypass_frame", bits, exp_frame(16'h8001, 16'h7FFE));
    chk("bypass_ready_after", 64'(ready_o), 64'd1);

    // underrun
    under_cnt = 0;
    run_frame(bits, n);
    chk("underrun_pulses", 64'(under_cnt), 64'd1);
`ifdef STUDENT_IIS_TX_MUTE_ON_UNDERRUN_EN
    chk("underrun_mute_frame", bits, 64'd0);
`else
    chk("underrun_repeat_frame", bits, exp_frame(16'h8001, 16'h7FFE));
`endif

    // back-pressure
    while ((gcnt % 256) != 128) tick();
    send_pair(16'h1234, 16'h5678);
    data_l  = 16'h9ABC;
    data_r  = 16'hDEF0;
    valid_i = 1'b1;
    repeat (5) tick();
    chk("bp_ready_low", 64'(ready_o), 64'd0);
    chk("bp_valid_held", 64'(valid_i), 64'd1);
    run_frame(bits, n);
    chk("bp_first_frame", bits, exp_frame(16'h1234, 16'h5678));
    chk("bp_second_taken", 64'(valid_i), 64'd0);
    run_frame(bits, n);
    chk("bp_second_frame", bits, exp_frame(16'h9ABC, 16'hDEF0));

    // reset after 7 bits of a word, with the holding register full
    data_l  = 16'hC3A5;
    data_r  = 16'h5A3C;
    valid_i = 1'b1;
    tick();
    send_pair(16'h1111, 16'h2222);
    while ((gcnt % 256) != 30) tick();
    chk("pre_reset_bit7", 64'(sdata), 64'd1);
    chk("pre_reset_ready", 64'(ready_o), 64'd0);
    rst_ni = 1'b0;
    #1;
    chk("midrst_sdata", 64'(sdata), 64'd0);
    chk("midrst_ready", 64'(ready_o), 64'd1);
    model_reset();
    repeat (2) tick();
    rst_ni = 1'b1;
    send_pair(16'h6C1E, 16'hE1C6);
    run_frame(bits, n);
    chk("post_reset_frame", bits, exp_frame(16'h6C1E, 16'hE1C6));

    repeat (4) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
